// File: rtl/fadd_arbiter.sv
// Round-robin arbiter that shares one fixed-latency float32 adder among NREQ requesters.
// One operation is in flight at a time. Each result is returned to its requester as a one-cycle pulse.
module fadd_arbiter #(
  parameter int NREQ = 4,
  parameter int LAT  = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*32-1:0]   req_a,
  input  logic [NREQ*32-1:0]   req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [31:0]          rsp_data,
  output logic [31:0]          add_a,
  output logic [31:0]          add_b,
  input  logic [31:0]          add_q,
  output logic                 busy
);

  localparam int IDXW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic [IDXW-1:0]   last_grant_q;
  logic [IDXW-1:0]   idx_q;
  logic [31:0]       add_a_q;
  logic [31:0]       add_b_q;
  logic [31:0]       rsp_data_q;
  logic [NREQ-1:0]   rsp_valid_q;
  logic              busy_q;

  logic              grant_vld_d;
  logic [IDXW-1:0]   grant_idx_d;
  logic [NREQ-1:0]   grant_oh_d;
  logic [31:0]       grant_a_d;
  logic [31:0]       grant_b_d;
  int                cand;

  // Search starts one past the last winner and wraps, so every active requester is served once per round.
  always_comb begin
    grant_vld_d = 1'b0;
    grant_idx_d = '0;
    grant_oh_d  = '0;
    grant_a_d   = '0;
    grant_b_d   = '0;
    cand        = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = (int'(last_grant_q) + 1 + k) % NREQ;
      if (!grant_vld_d && req_valid[cand]) begin
        grant_vld_d = 1'b1;
        grant_idx_d = IDXW'(cand);
        grant_a_d   = req_a[cand*32 +: 32];
        grant_b_d   = req_b[cand*32 +: 32];
      end
    end
    if (grant_vld_d) begin
      grant_oh_d[grant_idx_d] = 1'b1;
    end
  end

  // The ready output is gated by rst_n so that it stays low during reset even if req_valid is high.
  assign req_ready = (rst_n && state_q == IDLE) ? grant_oh_d : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= IDXW'(NREQ - 1);
      idx_q        <= '0;
      add_a_q      <= '0;
      add_b_q      <= '0;
      rsp_data_q   <= '0;
      rsp_valid_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_vld_d) begin
            state_q      <= RUN;
            idx_q        <= grant_idx_d;
            last_grant_q <= grant_idx_d;
            cnt_q        <= 4'(LAT - 1);
            add_a_q      <= grant_a_d;
            add_b_q      <= grant_b_d;
            busy_q       <= 1'b1;
          end
        end
        RUN: begin
          if (cnt_q == 4'd0) begin
            // The operands are cleared here so that back-to-back identical operations still present an edge to the adder.
            state_q     <= RESP;
            rsp_data_q  <= add_q;
            add_a_q     <= '0;
            add_b_q     <= '0;
            rsp_valid_q <= NREQ'(1) << idx_q;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          state_q     <= IDLE;
          rsp_valid_q <= '0;
          busy_q      <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_fadd_arbiter.sv
// Directed testbench for fadd_arbiter. It uses a table of single operations plus hand-written multi-cycle sequences.
// A small adder model returns float sums for known operand pairs after LAT cycles.
module tb_fadd_arbiter;

  localparam int NREQ = 4;
  localparam int LAT  = 6;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*32-1:0]  req_a;
  logic [NREQ*32-1:0]  req_b;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ-1:0]     rsp_valid;
  logic [31:0]         rsp_data;
  logic [31:0]         add_a;
  logic [31:0]         add_b;
  logic [31:0]         add_q;
  logic                busy;

  int checks = 0;
  int errors = 0;

  fadd_arbiter #(.NREQ(NREQ), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .add_a(add_a), .add_b(add_b), .add_q(add_q), .busy(busy)
  );

  always #5 clk = ~clk;

  // Adder model: returns the sum for known operand pairs and a marker value otherwise.
  // The result becomes valid LAT cycles after the operands first appear.
  function automatic logic [31:0] faddModel(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h3F800000, 32'h40000000}: return 32'h40400000;
      {32'h3F800000, 32'h3F800000}: return 32'h40000000;
      {32'h40000000, 32'h40000000}: return 32'h40800000;
      {32'h3F000000, 32'h3F000000}: return 32'h3F800000;
      default:                      return 32'hDEADBEEF;
    endcase
  endfunction

  logic [31:0] pipe [LAT-1];
  always_ff @(posedge clk) begin
    pipe[0] <= faddModel(add_a, add_b);
    for (int i = 1; i < LAT - 1; i++) pipe[i] <= pipe[i-1];
  end
  assign add_q = pipe[LAT-2];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] valid, input int idx,
                               input logic [31:0] a, input logic [31:0] b);
    req_valid          = valid;
    req_a[idx*32 +: 32] = a;
    req_b[idx*32 +: 32] = b;
  endtask

  typedef struct {
    int          idx;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sum;
  } opVec_t;

  opVec_t vecs [4];

  // This task issues one operation and withdraws it at T+1 with scrambled operands.
  // It then checks the latched operands during RUN and the response at T+LAT+1.
  task automatic runOp(input opVec_t v);
    logic [NREQ-1:0] oh;
    oh = NREQ'(1) << v.idx;
    @(negedge clk);
    applyStimulus(oh, v.idx, v.a, v.b);
    #1;
    checkOutput("grant_ready", 32'(req_ready), 32'(oh));
    checkOutput("grant_busy", 32'(busy), 32'd0);
    @(negedge clk);
    applyStimulus('0, v.idx, 32'hFFFFFFFF, 32'h12345678);
    #1;
    for (int c = 1; c <= LAT; c++) begin
      if (c > 1) begin
        @(negedge clk);
        #1;
      end
      checkOutput("run_add_a", add_a, v.a);
      checkOutput("run_add_b", add_b, v.b);
      checkOutput("run_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("run_ready", 32'(req_ready), 32'd0);
      checkOutput("run_busy", 32'(busy), 32'd1);
    end
    @(negedge clk);
    #1;
    checkOutput("resp_valid", 32'(rsp_valid), 32'(oh));
    checkOutput("resp_data", rsp_data, v.sum);
    checkOutput("resp_add_a", add_a, 32'd0);
    checkOutput("resp_busy", 32'(busy), 32'd1);
    @(negedge clk);
    #1;
    checkOutput("post_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("post_busy", 32'(busy), 32'd0);
    checkOutput("post_rsp_hold", rsp_data, v.sum);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int gIdx [5];
    int gCyc [5];
    int expOrder [5];
    int n;

    vecs[0] = '{2, 32'h3F800000, 32'h40000000, 32'h40400000};
    vecs[1] = '{0, 32'h3F800000, 32'h3F800000, 32'h40000000};
    vecs[2] = '{3, 32'h40000000, 32'h40000000, 32'h40800000};
    vecs[3] = '{1, 32'h3F000000, 32'h3F000000, 32'h3F800000};
    expOrder = '{0, 1, 2, 3, 0};

    rst_n = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    #2;
    req_valid = 4'b0100;
    #1;
    checkOutput("reset_ready", 32'(req_ready), 32'd0);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_add_a", add_a, 32'd0);
    checkOutput("reset_add_b", add_b, 32'd0);
    checkOutput("reset_rsp_data", rsp_data, 32'd0);
    req_valid = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) runOp(vecs[i]);

    // Back-to-back operations from requester 1. The adder must see zero operands between them.
    @(negedge clk);
    applyStimulus(4'b0010, 1, 32'h3F000000, 32'h3F000000);
    #1;
    checkOutput("b2b_grant1", 32'(req_ready), 32'h2);
    for (int c = 1; c <= LAT; c++) begin
      @(negedge clk);
      #1;
      checkOutput("b2b_run1_add_a", add_a, 32'h3F000000);
    end
    @(negedge clk);
    #1;
    checkOutput("b2b_resp1_valid", 32'(rsp_valid), 32'h2);
    checkOutput("b2b_resp1_data", rsp_data, 32'h3F800000);
    checkOutput("b2b_gap_add_a", add_a, 32'd0);
    @(negedge clk);
    #1;
    checkOutput("b2b_grant2", 32'(req_ready), 32'h2);
    checkOutput("b2b_idle_add_a", add_a, 32'd0);
    @(negedge clk);
    req_valid = '0;
    #1;
    checkOutput("b2b_run2_add_a", add_a, 32'h3F000000);
    for (int c = 2; c <= LAT; c++) begin
      @(negedge clk);
      #1;
      checkOutput("b2b_run2_add_a", add_a, 32'h3F000000);
    end
    @(negedge clk);
    #1;
    checkOutput("b2b_resp2_valid", 32'(rsp_valid), 32'h2);
    checkOutput("b2b_resp2_data", rsp_data, 32'h3F800000);
    @(negedge clk);

    // Assert reset in the middle of an operation. Afterwards the grant pointer must start again at requester 0.
    @(negedge clk);
    applyStimulus(4'b0100, 2, 32'h3F800000, 32'h40000000);
    #1;
    checkOutput("rst_grant", 32'(req_ready), 32'h4);
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      #1;
      checkOutput("rst_run_ready", 32'(req_ready), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_mid_busy", 32'(busy), 32'd0);
    checkOutput("rst_mid_add_a", add_a, 32'd0);
    checkOutput("rst_mid_add_b", add_b, 32'd0);
    checkOutput("rst_mid_rsp_data", rsp_data, 32'd0);
    checkOutput("rst_mid_ready", 32'(req_ready), 32'd0);
    repeat (3) begin
      @(negedge clk);
      #1;
      checkOutput("rst_hold_rsp_valid", 32'(rsp_valid), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(4'b1001, 0, 32'h3F800000, 32'h3F800000);
    applyStimulus(4'b1001, 3, 32'h40000000, 32'h40000000);
    #1;
    checkOutput("rst_after_grant", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = '0;
    repeat (LAT) @(negedge clk);
    #1;
    checkOutput("rst_after_rsp_valid", 32'(rsp_valid), 32'h1);
    checkOutput("rst_after_rsp_data", rsp_data, 32'h40000000);
    @(negedge clk);

    // Round-robin test: all four requesters are held active from reset release.
    rst_n = 1'b0;
    req_valid = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    req_valid = 4'hF;
    n = 0;
    for (int c = 0; c < 60 && n < 5; c++) begin
      #1;
      if (req_ready != '0) begin
        checkOutput("rr_onehot", 32'($countones(req_ready)), 32'd1);
        for (int k = 0; k < NREQ; k++) if (req_ready[k]) gIdx[n] = k;
        gCyc[n] = c;
        n++;
      end
      @(negedge clk);
    end
    checkOutput("rr_grant_count", 32'(n), 32'd5);
    checkOutput("rr_first_cycle", 32'(gCyc[0]), 32'd0);
    for (int i = 0; i < 5 && i < n; i++) begin
      checkOutput("rr_order", 32'(gIdx[i]), 32'(expOrder[i]));
      if (i > 0) checkOutput("rr_spacing", 32'(gCyc[i] - gCyc[i-1]), 32'(LAT + 2));
    end
    req_valid = '0;
    repeat (LAT + 3) @(negedge clk);

    // Idle hold for 100 cycles.
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      #1;
      checkOutput("idle_ctrl", 32'({busy, req_ready, rsp_valid}), 32'd0);
      checkOutput("idle_operands", add_a | add_b, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
